// File: rtl/uart_boot_loader_pkg.sv
// ============================================================================
// Module  : uart_boot_loader_pkg
// Purpose : Shared state encoding and default protocol constants for the loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT   = 8'h4B;
    localparam logic [7:0] NAK_DEFAULT   = 8'h45;

endpackage

`default_nettype wire

// File: rtl/uart_boot_loader_word_asm.sv
// ============================================================================
// Module  : loader_word_asm
// Purpose : Little-endian 4-byte assembler; word_ready flags the 4th byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift;
    logic [1:0]  idx;

    // The completed word is presented combinationally alongside the 4th byte
    // so the parent can register it into the bus the following cycle.
    assign word       = {byte_data, shift};
    assign word_ready = byte_valid && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            shift <= '0;
            idx   <= '0;
        end else if (byte_valid) begin
            shift <= {byte_data, shift[23:8]};
            idx   <= idx + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader.sv
// ============================================================================
// Module  : uart_boot_loader
// Purpose : UART-framed image loader writing words to SRAM over the data bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT,
    parameter int unsigned RAM_WORDS = 65536,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter logic [7:0]  ACK       = ACK_DEFAULT,
    parameter logic [7:0]  NAK       = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data,
    output logic        bus_we,
    output logic        stall_cpu,
    output logic        boot_done
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [2:0]  byte_cnt;
    logic [31:0] addr;
    logic [31:0] count;
    logic [31:0] word_cnt;
    logic [31:0] tmo;
    logic [7:0]  csum;
    logic        err;

    logic        in_frame;
    logic        timeout_hit;
    logic        csum_bad;
    logic        enter_resp;
    logic [31:0] hdr_count;
    logic [31:0] asm_word;
    logic        word_ready;

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .byte_valid (rx_valid && (state == DATA)),
        .byte_data  (rx_data),
        .word       (asm_word),
        .word_ready (word_ready)
    );

    assign in_frame    = (state == HDR) || (state == DATA) || (state == CSUM);
    assign timeout_hit = in_frame && !rx_valid && (tmo == TMO_LAST);
    assign csum_bad    = (state == CSUM) && rx_valid && (rx_data != csum);
    assign hdr_count   = {rx_data, count[31:8]};
    assign enter_resp  = (state != RESP) && (next_state == RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rx_valid && rx_data == MAGIC) next_state = HDR;
            HDR: begin
                if (rx_valid && byte_cnt == 3'd7) begin
                    next_state = (hdr_count == 32'd0) ? CSUM : DATA;
                end else if (timeout_hit) begin
                    next_state = RESP;
                end
            end
            DATA: begin
                if (word_ready && (word_cnt + 32'd1) == count) begin
                    next_state = CSUM;
                end else if (timeout_hit) begin
                    next_state = RESP;
                end
            end
            CSUM: if (rx_valid || timeout_hit) next_state = RESP;
            RESP: if (tx_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt  <= '0;
            addr      <= '0;
            count     <= '0;
            word_cnt  <= '0;
            tmo       <= '0;
            csum      <= '0;
            err       <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_we    <= 1'b0;
            stall_cpu <= 1'b0;
            boot_done <= 1'b0;
        end else begin
            bus_we <= 1'b0;
            tmo    <= (in_frame && !rx_valid) ? tmo + 32'd1 : 32'd0;

            if (state == IDLE && rx_valid && rx_data == MAGIC) begin
                byte_cnt  <= '0;
                csum      <= '0;
                err       <= 1'b0;
                word_cnt  <= '0;
                stall_cpu <= 1'b1;
            end

            if (state == HDR && rx_valid) begin
                byte_cnt <= byte_cnt + 3'd1;
                if (!byte_cnt[2]) begin
                    addr <= {rx_data, addr[31:8]};
                end else begin
                    count <= hdr_count;
                end
            end

            if (state == DATA && rx_valid) begin
                csum <= csum ^ rx_data;
            end

            // Out-of-range words are discarded but still advance the frame.
            if (word_ready) begin
                if (addr < RAM_LIMIT) begin
                    bus_we   <= 1'b1;
                    bus_addr <= addr;
                    bus_data <= asm_word;
                end else begin
                    err <= 1'b1;
                end
                addr     <= addr + 32'd1;
                word_cnt <= word_cnt + 32'd1;
            end

            if (enter_resp) begin
                tx_valid <= 1'b1;
                tx_data  <= (err || csum_bad || timeout_hit) ? NAK : ACK;
                err      <= err || csum_bad || timeout_hit;
            end

            if (state == RESP && tx_ready) begin
                tx_valid  <= 1'b0;
                stall_cpu <= 1'b0;
                if (!err) boot_done <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
